// File: rtl/ptp_frame_parser.sv
// ptp_frame_parser: per-direction GMII parser that timestamps PTP layer-2 event
// messages at the SFD and writes one 128-bit record per valid event message.
// Ports:
//   clk, rst           GMII byte clock, async active-high reset
//   gmii_ctrl          frame valid (DV/EN)
//   gmii_data[7:0]     GMII byte
//   rtc_time_in[79:0]  RTC time {sec[47:0], ns[31:0]}, synchronous to clk
//   q_full             timestamp queue full
//   q_wr_en            one-cycle queue write strobe
//   q_wr_data[127:0]   {12'h0, msgType, seqId, 16'h0, timestamp}
//   drop_cnt[7:0]      records lost to q_full, saturating
module ptp_frame_parser #(
    parameter logic [15:0] ETHERTYPE = 16'h88F7,
    parameter bit          VLAN_EN   = 1'b1,
    parameter logic [3:0]  PTP_VER   = 4'h2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         gmii_ctrl,
    input  logic [7:0]   gmii_data,
    input  logic [79:0]  rtc_time_in,
    input  logic         q_full,
    output logic         q_wr_en,
    output logic [127:0] q_wr_data,
    output logic [7:0]   drop_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        ETH_HDR,
        PTP_HDR,
        WAIT_END
    } state_t;

    state_t      state, state_n;
    logic [5:0]  cnt, cnt_n;
    logic        vlan, vlan_n;
    logic [7:0]  prev;
    logic [79:0] ts;
    logic [3:0]  msg_type;
    logic [3:0]  version;
    logic [15:0] seq_id;
    logic        sfd_hit;
    logic        issue;
    logic        et_cmp;
    logic [15:0] etype;

    // The EtherType is the previous byte plus the current one; where it
    // sits depends on whether an 802.1Q tag has already been skipped.
    assign etype  = {prev, gmii_data};
    assign et_cmp = vlan ? (cnt == 6'd17) : (cnt == 6'd13);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        vlan_n  = vlan;
        sfd_hit = 1'b0;
        issue   = 1'b0;
        if (!gmii_ctrl) begin
            state_n = IDLE;
            cnt_n   = 6'd0;
            vlan_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = (gmii_data == 8'h55) ? PREAMBLE : WAIT_END;
                end
                PREAMBLE: begin
                    if (gmii_data == 8'hD5) begin
                        state_n = ETH_HDR;
                        sfd_hit = 1'b1;
                        cnt_n   = 6'd0;
                        vlan_n  = 1'b0;
                    end else if (gmii_data != 8'h55) begin
                        state_n = WAIT_END;
                    end
                end
                ETH_HDR: begin
                    cnt_n = cnt + 6'd1;
                    if (et_cmp) begin
                        // Only one tag is skipped; a second 8100 falls
                        // through to the EtherType compare and fails.
                        if (VLAN_EN && !vlan && etype == 16'h8100) begin
                            vlan_n = 1'b1;
                        end else if (etype == ETHERTYPE) begin
                            state_n = PTP_HDR;
                            cnt_n   = 6'd0;
                        end else begin
                            state_n = WAIT_END;
                        end
                    end
                end
                PTP_HDR: begin
                    cnt_n = cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state_n = WAIT_END;
                        issue   = (msg_type <= 4'h3) && (version == PTP_VER);
                    end
                end
                WAIT_END: begin
                    state_n = WAIT_END;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 6'd0;
            vlan  <= 1'b0;
            prev  <= 8'h00;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            vlan  <= vlan_n;
            prev  <= gmii_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts        <= '0;
            msg_type  <= 4'h0;
            version   <= 4'h0;
            seq_id    <= 16'h0;
            q_wr_en   <= 1'b0;
            q_wr_data <= '0;
            drop_cnt  <= 8'h00;
        end else begin
            q_wr_en <= 1'b0;
            if (sfd_hit) begin
                ts <= rtc_time_in;
            end
            if (gmii_ctrl && state == PTP_HDR) begin
                if (cnt == 6'd0) msg_type <= gmii_data[3:0];
                if (cnt == 6'd1) version <= gmii_data[3:0];
                if (cnt == 6'd30) seq_id[15:8] <= gmii_data;
                if (cnt == 6'd31) seq_id[7:0] <= gmii_data;
            end
            if (issue) begin
                if (!q_full) begin
                    q_wr_en   <= 1'b1;
                    q_wr_data <= {12'h0, msg_type, seq_id[15:8],
                                  gmii_data, 16'h0, ts};
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ptp_frame_parser.sv
// tb_ptp_frame_parser: random and directed frames against a byte-array
// reference model; expected records are queued and checked by monitors.
module tb_ptp_frame_parser;

    logic         clk;
    logic         rst;
    logic         gmii_ctrl;
    logic [7:0]   gmii_data;
    logic [79:0]  rtc_time_in;
    logic         q_full;
    logic         wr_en0, wr_en1;
    logic [127:0] wr_data0, wr_data1;
    logic [7:0]   drop0, drop1;

    typedef struct {
        logic [127:0] rec;
        int           cyc;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] frm [64];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         mdrop0 = 0;
    int         mdrop1 = 0;

    ptp_frame_parser #(.VLAN_EN(1'b1)) u0 (
        .clk(clk), .rst(rst), .gmii_ctrl(gmii_ctrl),
        .gmii_data(gmii_data), .rtc_time_in(rtc_time_in),
        .q_full(q_full), .q_wr_en(wr_en0), .q_wr_data(wr_data0),
        .drop_cnt(drop0)
    );

    ptp_frame_parser #(.VLAN_EN(1'b0)) u1 (
        .clk(clk), .rst(rst), .gmii_ctrl(gmii_ctrl),
        .gmii_data(gmii_data), .rtc_time_in(rtc_time_in),
        .q_full(q_full), .q_wr_en(wr_en1), .q_wr_data(wr_data1),
        .drop_cnt(drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [79:0] rnd80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    // Reference: locate EtherType and PTP header by byte position in the
    // frame and apply the acceptance rules directly.
    function automatic bit model(input bit ven, input int len,
                                 input bit pbad, input logic [79:0] t,
                                 output logic [127:0] rec,
                                 output int hdr);
        logic [15:0] et;
        int p;
        rec = '0;
        hdr = 14;
        if (pbad) return 1'b0;
        p  = 12;
        et = {frm[12], frm[13]};
        if (ven && et == 16'h8100) begin
            p  = 16;
            et = {frm[16], frm[17]};
        end
        hdr = p + 2;
        if (et != 16'h88F7) return 1'b0;
        if (len < hdr + 32) return 1'b0;
        if (frm[hdr][3:0] > 4'd3) return 1'b0;
        if (frm[hdr+1][3:0] != 4'h2) return 1'b0;
        rec = {12'h0, frm[hdr][3:0], frm[hdr+30], frm[hdr+31], 16'h0, t};
        return 1'b1;
    endfunction

    task automatic build(input bit vl, input logic [15:0] et,
                         input logic [7:0] mb, input logic [7:0] vb,
                         input logic [15:0] seq);
        int h;
        for (int i = 0; i < 64; i++) frm[i] = 8'($urandom);
        h = vl ? 16 : 12;
        if (vl) begin
            frm[12] = 8'h81;
            frm[13] = 8'h00;
        end
        frm[h]   = et[15:8];
        frm[h+1] = et[7:0];
        h = h + 2;
        frm[h]    = mb;
        frm[h+1]  = vb;
        frm[h+30] = seq[15:8];
        frm[h+31] = seq[7:0];
    endtask

    task automatic chk_reset_outs();
        chk("rst_wr_en0", 128'(wr_en0), 128'd0);
        chk("rst_wr_data0", wr_data0, 128'd0);
        chk("rst_drop0", 128'(drop0), 128'd0);
        chk("rst_wr_en1", 128'(wr_en1), 128'd0);
        chk("rst_wr_data1", wr_data1, 128'd0);
        chk("rst_drop1", 128'(drop1), 128'd0);
    endtask

    task automatic send(input int len, input int npre, input bit pbad,
                        input bit qf, input int rst_at, input int gap,
                        input logic [79:0] t);
        logic [127:0] r;
        int hdr;
        exp_t e;
        q_full = qf;
        for (int i = 0; i < npre; i++) begin
            @(negedge clk);
            gmii_ctrl   = 1'b1;
            gmii_data   = (pbad && i == npre - 1) ? 8'h5A : 8'h55;
            rtc_time_in = rnd80();
        end
        @(negedge clk);
        gmii_ctrl   = 1'b1;
        gmii_data   = 8'hD5;
        rtc_time_in = t;
        if (rst_at < 0) begin
            if (model(1'b1, len, pbad, t, r, hdr)) begin
                if (!qf) begin
                    e.rec = r;
                    e.cyc = cyc + 33 + hdr;
                    q0.push_back(e);
                end else if (mdrop0 < 255) begin
                    mdrop0++;
                end
            end
            if (model(1'b0, len, pbad, t, r, hdr)) begin
                if (!qf) begin
                    e.rec = r;
                    e.cyc = cyc + 33 + hdr;
                    q1.push_back(e);
                end else if (mdrop1 < 255) begin
                    mdrop1++;
                end
            end
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            gmii_data   = frm[i];
            rtc_time_in = rnd80();
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk_reset_outs();
                rst    = 1'b0;
                mdrop0 = 0;
                mdrop1 = 0;
            end
        end
        @(negedge clk);
        gmii_ctrl = 1'b0;
        gmii_data = 8'($urandom);
        for (int i = 1; i < gap; i++) @(negedge clk);
        chk("drop_cnt0", 128'(drop0), 128'(mdrop0));
        chk("drop_cnt1", 128'(drop1), 128'(mdrop1));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && wr_en0) begin
            if (q0.size() == 0) begin
                chk("u0_unexpected_write", wr_data0, 128'd0);
                if (wr_data0 == 128'd0) begin
                    bad++;
                    $display("FAIL u0_unexpected_write act=1 exp=0");
                end
            end else begin
                e = q0.pop_front();
                chk("u0_record", wr_data0, e.rec);
                chk("u0_latency", 128'(cyc), 128'(e.cyc));
            end
        end
        if (!rst && wr_en1) begin
            if (q1.size() == 0) begin
                chk("u1_unexpected_write", wr_data1, 128'd0);
                if (wr_data1 == 128'd0) begin
                    bad++;
                    $display("FAIL u1_unexpected_write act=1 exp=0");
                end
            end else begin
                e = q1.pop_front();
                chk("u1_record", wr_data1, e.rec);
                chk("u1_latency", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    initial begin
        bit vl;
        logic [15:0] et;
        int len;
        rst         = 1'b1;
        gmii_ctrl   = 1'b0;
        gmii_data   = 8'h00;
        rtc_time_in = '0;
        q_full      = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs();
        rst = 1'b0;
        @(negedge clk);

        build(1'b0, 16'h88F7, 8'h00, 8'h02, 16'h1234);
        send(64, 7, 1'b0, 1'b0, -1, 2, 80'h0000_0000_0001_3B9A_C9FF);
        chk("sync_vector", wr_data0,
            {12'h0, 4'h0, 16'h1234, 16'h0, 80'h0000_0000_0001_3B9A_C9FF});

        build(1'b1, 16'h88F7, 8'h01, 8'h02, 16'hBEEF);
        send(64, 7, 1'b0, 1'b0, -1, 2, rnd80());

        build(1'b0, 16'h0800, 8'h00, 8'h02, 16'h0001);
        send(64, 7, 1'b0, 1'b0, -1, 2, rnd80());
        build(1'b0, 16'h88F7, 8'h08, 8'h02, 16'h0002);
        send(64, 7, 1'b0, 1'b0, -1, 2, rnd80());
        build(1'b0, 16'h88F7, 8'h00, 8'h01, 16'h0003);
        send(64, 7, 1'b0, 1'b0, -1, 2, rnd80());
        build(1'b0, 16'h88F7, 8'h00, 8'h02, 16'h0004);
        send(34, 7, 1'b0, 1'b0, -1, 2, rnd80());
        build(1'b1, 16'h8100, 8'h00, 8'h02, 16'h0005);
        send(64, 7, 1'b0, 1'b0, -1, 2, rnd80());

        for (int n = 0; n < 300; n++) begin
            build(1'b0, 16'h88F7, 8'(n % 4), 8'h02, 16'(n));
            send(46, 2, 1'b0, 1'b1, -1, 1, rnd80());
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outs();
        rst    = 1'b0;
        mdrop0 = 0;
        mdrop1 = 0;
        @(negedge clk);

        for (int n = 0; n < 2; n++) begin
            build(1'b0, 16'h88F7, 8'h02, 8'h02, 16'(16'hA000 + n));
            send(46, 3, 1'b0, 1'b0, -1, 1, rnd80());
        end

        build(1'b0, 16'h88F7, 8'h00, 8'h02, 16'h5555);
        frm[11] = 8'h00;
        send(64, 7, 1'b0, 1'b0, 10, 2, rnd80());

        for (int n = 0; n < 200; n++) begin
            vl = 1'($urandom);
            case ($urandom_range(0, 9))
                0:       et = 16'h0800;
                1:       et = 16'h8100;
                default: et = 16'h88F7;
            endcase
            build(vl, et, {4'($urandom), 4'($urandom_range(0, 9))},
                  {4'($urandom), ($urandom_range(0, 5) == 0) ?
                   4'($urandom) : 4'h2}, 16'($urandom));
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 63) : 64;
            send(len, $urandom_range(1, 7), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 5) == 0, -1, $urandom_range(1, 3),
                 rnd80());
        end

        repeat (4) @(negedge clk);
        chk("u0_queue_empty", 128'(q0.size()), 128'd0);
        chk("u1_queue_empty", 128'(q1.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ptp_frame_parser.md
# ptp_frame_parser

Per-direction GMII frame parser on the timestamp unit's input side: watches one GMII byte stream, latches the RTC time at the start-of-frame delimiter, and decodes Ethernet/PTP (layer-2) headers. For every valid PTP event message it writes one 128-bit record (messageType, sequenceId, timestamp) into the timestamp queue. One instance sits on the rx path and one on the tx path; each runs on that path's GMII clock.

## Interface
- ETHERTYPE, 16'h88F7, EtherType accepted as PTP.
- VLAN_EN, 1, when 1 a single 802.1Q tag (TPID 16'h8100) before the EtherType is skipped.
- PTP_VER, 4'h2, required value of versionPTP (low nibble of PTP byte 1).
- clk  in  1  GMII byte clock (rising edge).
- rst  in  1  asynchronous, active-high reset.
- gmii_ctrl  in  1  frame valid (GMII DV/EN).
- gmii_data  in  8  GMII byte.
- rtc_time_in  in  80  RTC time, already synchronized to clk; [79:32] seconds, [31:0] nanoseconds.
- q_full  in  1  timestamp queue full.
- q_wr_en  out  1  one-cycle queue write strobe.
- q_wr_data  out  128  queue record: [127:116] zero, [115:112] messageType, [111:96] sequenceId, [95:80] zero, [79:0] timestamp.
- drop_cnt  out  8  records lost to q_full; saturates at 8'hFF.

## Operation
- FSM states: IDLE, PREAMBLE, ETH_HDR, PTP_HDR, WAIT_END.
- Every state: gmii_ctrl=0 -> IDLE next cycle, counters cleared. No record is emitted for a truncated frame.
- IDLE: ctrl=1 and data=8'h55 -> PREAMBLE. ctrl=1 with any other byte -> WAIT_END.
- PREAMBLE:
  - 8'h55 -> stay.
  - 8'hD5 (SFD) -> ETH_HDR; latch rtc_time_in into the timestamp register; clear the 6-bit byte counter.
  - Any other byte -> WAIT_END.
- ETH_HDR: byte counter counts bytes after SFD, starting at 0. Bytes 0-11 (MACs) are ignored. EtherType is bytes 12-13.
  - VLAN_EN=1 and bytes 12-13 = 16'h8100: EtherType is taken from bytes 16-17 instead.
  - EtherType = ETHERTYPE -> PTP_HDR; PTP offset counter cleared.
  - Any other value -> WAIT_END.
  - A second 8'h8100 tag is not skipped; it is treated as a mismatch.
- PTP_HDR: offset counter counts PTP header bytes from 0.
  - Offset 0: latch messageType = data[3:0].
  - Offset 1: latch version = data[3:0].
  - Offsets 30-31: sequenceId, big-endian.
  - At offset 31: if messageType <= 4'h3 (Sync, Delay_Req, Pdelay_Req, Pdelay_Resp) and version = PTP_VER, issue a record; in all cases -> WAIT_END.
- Record issue:
  - q_full=0: q_wr_en=1 for one cycle, with q_wr_data.
  - q_full=1: no write; drop_cnt increments, saturating.
- WAIT_END: ignore bytes until ctrl=0.
- Timestamp register, messageType, sequenceId and drop_cnt are held until overwritten; only rst clears drop_cnt.

## Timing
- Reset values: state=IDLE, q_wr_en=0, q_wr_data=0, drop_cnt=0, all internal registers 0.
- rst assertion mid-frame aborts immediately. After release the FSM waits in IDLE, and the rest of the aborted frame goes to WAIT_END unless its current byte is 8'h55.
- Timestamp = rtc_time_in sampled on the same edge that samples SFD with ctrl=1.
- q_wr_en and q_wr_data are registered. They are valid the cycle after the edge sampling PTP offset 31, i.e. 45 cycles after SFD untagged, 49 with VLAN.
- q_wr_data is stable while q_wr_en=1 and holds afterwards. q_full is sampled on the same edge as offset 31.
- Back-to-back frames: one ctrl=0 cycle between frames is sufficient. A preamble on the cycle after ctrl=0 is parsed normally.
- Counters are 6-bit. They cannot wrap, because parsing ends by PTP offset 31 at byte 49.

## Test plan
- Untagged Sync: 7x55, D5, rtc_time_in=80'h0000_0000_0001_3B9A_C9FF at SFD, EtherType 88F7, msg 0x0, ver 0x2, seqId 16'h1234 -> one q_wr_en 45 cycles after SFD, q_wr_data = {12'h0, 4'h0, 16'h1234, 16'h0, 80'h0000_0000_0001_3B9A_C9FF}.
- VLAN-tagged Delay_Req: 8100 tag then 88F7, msg 0x1, seqId 16'hBEEF -> record 49 cycles after SFD with messageType 1 and seqId BEEF. Repeat with VLAN_EN=0 -> no write.
- Filtering, no write in any case: EtherType 0800; msg 0x8 (Follow_Up); version 1; ctrl dropped at PTP offset 20.
- q_full=1 at offset 31 for 300 valid frames -> no q_wr_en, drop_cnt reaches 8'hFF and holds. After rst -> drop_cnt=0.
- Two valid frames separated by a single ctrl=0 cycle -> two records, each with its own SFD timestamp. rst pulse mid-header -> no record, outputs at reset values.
